commit_trace_checker: RTL and testbench



---
 rtl/trace_pkg.sv | 37 +++
 rtl/trace_fifo.sv | 61 ++++++
 rtl/commit_trace_checker.sv | 209 ++++++++++++++++++++
 tb/tb_commit_trace_checker.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the commit trace checker.
//   - record type codes carried in bits [33:32] of a trace record
//   - error codes reported on err_code
//   - TRACE_REC_W, the packed record width {type, key, value}
//   - the checker FSM state encoding
//   - pack_rec(): builds a record from its three fields
package trace_pkg;

    localparam int TRACE_REC_W = 34;

    typedef enum logic [1:0] {
        REC_END   = 2'b00,
        REC_REG   = 2'b01,
        REC_LOAD  = 2'b10,
        REC_STORE = 2'b11
    } rec_type_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_MISMATCH = 3'd1;
    localparam logic [2:0] ERR_OVERFLOW = 3'd2;
    localparam logic [2:0] ERR_SHORT    = 3'd3;
    localparam logic [2:0] ERR_LONG     = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_WAIT_END = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    function automatic logic [TRACE_REC_W-1:0] pack_rec(input logic [1:0]  rec_type,
                                                       input logic [15:0] key,
                                                       input logic [15:0] value);
        return {rec_type, key, value};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO of observed trace records.
//   clk, rst        clock and synchronous active-high reset
//   push_cnt_i      number of records pushed this cycle (0..2)
//   push0_i/push1_i records in push order (push0_i goes in first)
//   pop_i           remove the head record
//   head_o          current head record (valid when !empty_o)
//   empty_o         no records stored
//   free_cnt_o      free slots before this cycle's push/pop
// The caller guarantees push_cnt_i never exceeds free_cnt_o + pop_i.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               push_cnt_i,
    input  logic [W-1:0]             push0_i,
    input  logic [W-1:0]             push1_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   free_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push_cnt_i);
            rd_ptr_q <= rd_ptr_q + PW'(pop_i);
            count_q  <= count_q + CW'(push_cnt_i) - CW'(pop_i);
        end
    end

    // Record storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_cnt_i != 2'd0) begin
            mem_q[wr_ptr_q] <= push0_i;
        end
        if (push_cnt_i == 2'd2) begin
            mem_q[wr_ptr_q + PTR_ONE] <= push1_i;
        end
    end

    assign head_o     = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign free_cnt_o = CW'(DEPTH) - count_q;

endmodule

// File: rtl/commit_trace_checker.sv
// commit_trace_checker: converts per-cycle commit events into trace records
// and checks them in order against an expected-trace memory.
//   clk, rst                      clock, synchronous active-high reset
//   RegWrite/WriteRegister/WriteData  register writeback event
//   MemRead/MemWrite/MemAddress/MemDataIn/MemDataOut  load/store event
//   Halt                          program finished (sticky halt_seen)
//   exp_req/exp_addr              one-cycle read request to expected memory
//   exp_valid/exp_rec             response {type, key, value}
//   done/pass                     finished / finished without error
//   err_code/err_index            first error cause and record index
//   inst_count                    committed instructions, saturating
module commit_trace_checker
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RegWrite,
    input  logic [2:0]             WriteRegister,
    input  logic [15:0]            WriteData,
    input  logic                   MemRead,
    input  logic                   MemWrite,
    input  logic [15:0]            MemAddress,
    input  logic [15:0]            MemDataIn,
    input  logic [15:0]            MemDataOut,
    input  logic                   Halt,
    output logic                   exp_req,
    output logic [AW-1:0]          exp_addr,
    input  logic                   exp_valid,
    input  logic [TRACE_REC_W-1:0] exp_rec,
    output logic                   done,
    output logic                   pass,
    output logic [2:0]             err_code,
    output logic [15:0]            err_index,
    output logic [31:0]            inst_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e                 state_q;
    logic [AW-1:0]          rec_idx_q;
    logic [AW-1:0]          rec_idx_d;
    logic                   halt_seen_q;
    logic [TRACE_REC_W-1:0] rec0_s;
    logic [TRACE_REC_W-1:0] rec1_s;
    logic [TRACE_REC_W-1:0] head_s;
    logic [1:0]             gen_cnt_s;
    logic [1:0]             push_cnt_s;
    logic [CW-1:0]          free_cnt_s;
    logic [CW:0]            avail_s;
    logic                   empty_s;
    logic                   active_s;
    logic                   pop_s;
    logic                   overflow_s;
    logic                   fail_s;
    logic [2:0]             fail_code_s;

    assign active_s  = (state_q != ST_DONE);
    assign gen_cnt_s = {1'b0, RegWrite} + {1'b0, MemRead} + {1'b0, MemWrite};
    // Every response in WAIT consumes the head, matched or not.
    assign pop_s     = (state_q == ST_WAIT) && exp_valid;
    // The slot being popped this cycle is usable by this cycle's push.
    assign avail_s   = {1'b0, free_cnt_s} + {{CW{1'b0}}, pop_s};
    // Three records in one cycle cannot be pushed by the dual-port FIFO either.
    assign overflow_s = active_s &&
                        (({{(CW-1){1'b0}}, gen_cnt_s} > avail_s) || (gen_cnt_s == 2'd3));
    assign push_cnt_s = (active_s && !overflow_s) ? gen_cnt_s : 2'd0;

    // Pack this cycle's events into at most two records in REG, LOAD, STORE order.
    always_comb begin
        rec0_s = pack_rec(REC_STORE, MemAddress, MemDataIn);
        rec1_s = pack_rec(REC_STORE, MemAddress, MemDataIn);
        if (RegWrite) begin
            rec0_s = pack_rec(REC_REG, {13'd0, WriteRegister}, WriteData);
            rec1_s = MemRead ? pack_rec(REC_LOAD, MemAddress, MemDataOut)
                             : pack_rec(REC_STORE, MemAddress, MemDataIn);
        end else if (MemRead) begin
            rec0_s = pack_rec(REC_LOAD, MemAddress, MemDataOut);
        end else begin
            rec0_s = pack_rec(REC_STORE, MemAddress, MemDataIn);
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (TRACE_REC_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_cnt_i (push_cnt_s),
        .push0_i    (rec0_s),
        .push1_i    (rec1_s),
        .pop_i      (pop_s),
        .head_o     (head_s),
        .empty_o    (empty_s),
        .free_cnt_o (free_cnt_s)
    );

    // Judge the current response and overflow; a response verdict outranks overflow.
    always_comb begin
        fail_s      = 1'b0;
        fail_code_s = ERR_NONE;
        rec_idx_d   = rec_idx_q;
        case (state_q)
            ST_WAIT: begin
                if (!exp_valid) begin
                    rec_idx_d = rec_idx_q;
                end else if (exp_rec == head_s) begin
                    rec_idx_d = rec_idx_q + {{(AW-1){1'b0}}, 1'b1};
                end else if (exp_rec[TRACE_REC_W-1 -: 2] == REC_END) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_SHORT;
                end else begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_MISMATCH;
                end
            end
            ST_WAIT_END: begin
                if (exp_valid && (exp_rec[TRACE_REC_W-1 -: 2] != REC_END)) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_LONG;
                end else begin
                    fail_s      = 1'b0;
                end
            end
            default: begin
                fail_s = 1'b0;
            end
        endcase
        if (!fail_s && overflow_s) begin
            fail_s      = 1'b1;
            fail_code_s = ERR_OVERFLOW;
        end else begin
            fail_code_s = fail_code_s;
        end
    end

    // Checker FSM with registered request and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rec_idx_q   <= '0;
            halt_seen_q <= 1'b0;
            exp_req     <= 1'b0;
            exp_addr    <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_code    <= ERR_NONE;
            err_index   <= 16'd0;
        end else begin
            exp_req   <= 1'b0;
            rec_idx_q <= rec_idx_d;
            if (active_s && Halt) begin
                halt_seen_q <= 1'b1;
            end
            if (fail_s) begin
                state_q   <= ST_DONE;
                done      <= 1'b1;
                err_code  <= fail_code_s;
                err_index <= 16'(rec_idx_d);
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // Drain observed records before asking for the END marker.
                        if (!empty_s) begin
                            exp_req  <= 1'b1;
                            exp_addr <= rec_idx_q;
                            state_q  <= ST_WAIT;
                        end else if (halt_seen_q) begin
                            exp_req  <= 1'b1;
                            exp_addr <= rec_idx_q;
                            state_q  <= ST_WAIT_END;
                        end
                    end
                    ST_WAIT: begin
                        if (exp_valid) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_WAIT_END: begin
                        if (exp_valid) begin
                            state_q <= ST_DONE;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_DONE;
                    end
                    default: begin
                        state_q <= ST_DONE;
                    end
                endcase
            end
        end
    end

    // Instruction counter; frozen once checking has finished.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_count <= 32'd0;
        end else if (active_s && (Halt || RegWrite || MemWrite) && (inst_count != 32'hFFFF_FFFF)) begin
            inst_count <= inst_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_commit_trace_checker.sv
`timescale 1ns/1ps
module tb_commit_trace_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite, MemRead, MemWrite, Halt;
    logic [2:0]  WriteRegister;
    logic [15:0] WriteData, MemAddress, MemDataIn, MemDataOut;
    logic        exp_req, exp_valid, done, pass;
    logic [15:0] exp_addr;
    logic [33:0] exp_rec;
    logic [2:0]  err_code;
    logic [15:0] err_index;
    logic [31:0] inst_count;

    always #5 clk = ~clk;

    commit_trace_checker #(.DEPTH(8), .AW(16)) dut (
        .clk(clk), .rst(rst),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddress(MemAddress),
        .MemDataIn(MemDataIn), .MemDataOut(MemDataOut), .Halt(Halt),
        .exp_req(exp_req), .exp_addr(exp_addr), .exp_valid(exp_valid), .exp_rec(exp_rec),
        .done(done), .pass(pass), .err_code(err_code), .err_index(err_index),
        .inst_count(inst_count)
    );

    typedef struct {
        bit rw; logic [2:0] wr; logic [15:0] wd;
        bit mr; bit mw; logic [15:0] addr; logic [15:0] din; logic [15:0] dout;
        bit halt;
    } cyc_t;

    typedef struct {
        bit pass; logic [2:0] code; logic [15:0] idx;
        bit chk_idx; bit chk_inst; logic [31:0] inst;
    } res_t;

    cyc_t        cyc_tab[$];
    logic [33:0] ref_recs[$];
    int          ref_inst;
    logic [33:0] mem [0:63];
    res_t        res_q[$];
    int          lat_min = 1, lat_max = 1;
    int          n_checks = 0, n_fail = 0;
    bit          resp_busy = 1'b0;
    int          resp_delivered = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic cyc_t mk(bit rw, logic [2:0] wr, logic [15:0] wd, bit mr, bit mw,
                                logic [15:0] addr, logic [15:0] din, logic [15:0] dout, bit halt);
        cyc_t c;
        c.rw = rw; c.wr = wr; c.wd = wd; c.mr = mr; c.mw = mw;
        c.addr = addr; c.din = din; c.dout = dout; c.halt = halt;
        return c;
    endfunction

    // Records the checker should observe, in commit order, and the instruction count.
    task automatic build_recs();
        ref_recs.delete();
        ref_inst = 0;
        foreach (cyc_tab[i]) begin
            if (cyc_tab[i].rw) ref_recs.push_back({2'b01, 13'd0, cyc_tab[i].wr, cyc_tab[i].wd});
            if (cyc_tab[i].mr) ref_recs.push_back({2'b10, cyc_tab[i].addr, cyc_tab[i].dout});
            if (cyc_tab[i].mw) ref_recs.push_back({2'b11, cyc_tab[i].addr, cyc_tab[i].din});
            if (cyc_tab[i].rw || cyc_tab[i].mw || cyc_tab[i].halt) ref_inst++;
        end
    endtask

    // Walk the expected trace against the observed records.
    function automatic res_t predict();
        res_t r;
        r.pass = 1'b0; r.code = 3'd0; r.idx = 16'd0; r.chk_idx = 1'b1;
        r.chk_inst = 1'b0; r.inst = 32'(ref_inst);
        for (int i = 0; i < 60; i++) begin
            if (i == ref_recs.size()) begin
                if (mem[i][33:32] == 2'b00) r.pass = 1'b1;
                else begin r.code = 3'd4; r.idx = 16'(i); end
                r.chk_inst = 1'b1;
                break;
            end
            if (mem[i] != ref_recs[i]) begin
                r.code = (mem[i][33:32] == 2'b00) ? 3'd3 : 3'd1;
                r.idx  = 16'(i);
                break;
            end
        end
        return r;
    endfunction

    // Expected-trace memory: one response per request after lat_min..lat_max cycles.
    initial begin
        exp_valid = 1'b0;
        exp_rec   = '0;
        forever begin
            @(negedge clk);
            if (rst) resp_delivered = 0;
            if (exp_req) begin
                logic [15:0] a;
                int          l;
                a = exp_addr;
                l = $urandom_range(lat_max, lat_min);
                resp_busy = 1'b1;
                repeat (l - 1) @(negedge clk);
                exp_valid = 1'b1;
                exp_rec   = mem[a[5:0]];
                if (!done) resp_delivered++;
                @(negedge clk);
                exp_valid = 1'b0;
                exp_rec   = '0;
                resp_busy = 1'b0;
            end
        end
    end

    // Monitor: request addresses must run 0,1,2,...; each done pops one expected result.
    initial begin
        int   req_idx;
        bit   done_prev;
        res_t r;
        req_idx = 0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_idx = 0;
                done_prev = 1'b0;
            end else begin
                if (exp_req) begin
                    check("exp_addr", 64'(exp_addr), 64'(req_idx));
                    req_idx++;
                end
                if (done && !done_prev) begin
                    if (res_q.size() == 0) begin
                        check("unexpected_done", 64'(done), 64'd0);
                    end else begin
                        r = res_q.pop_front();
                        check("pass", 64'(pass), 64'(r.pass));
                        check("err_code", 64'(err_code), 64'(r.code));
                        if (r.chk_idx) check("err_index", 64'(err_index), 64'(r.idx));
                        if (r.chk_inst) check("inst_count", 64'(inst_count), 64'(r.inst));
                    end
                end
                done_prev = done;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_inputs();
        RegWrite = 1'b0; WriteRegister = 3'd0; WriteData = 16'd0;
        MemRead = 1'b0; MemWrite = 1'b0; MemAddress = 16'd0;
        MemDataIn = 16'd0; MemDataOut = 16'd0; Halt = 1'b0;
    endtask

    task automatic drive(input cyc_t c);
        RegWrite = c.rw; WriteRegister = c.wr; WriteData = c.wd;
        MemRead = c.mr; MemWrite = c.mw; MemAddress = c.addr;
        MemDataIn = c.din; MemDataOut = c.dout; Halt = c.halt;
        idle(1);
        clear_inputs();
    endtask

    task automatic wait_resp_idle();
        for (int i = 0; i < 20 && resp_busy; i++) idle(1);
    endtask

    task automatic do_reset();
        wait_resp_idle();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        res_q.delete();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 34'd0;
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (!done && k < bound) begin idle(1); k++; end
        if (!done) check("done_timeout", 64'(done), 64'd1);
        idle(2);
        check("result_consumed", 64'(res_q.size()), 64'd0);
        res_q.delete();
    endtask

    task automatic run_seq(input int gap);
        build_recs();
        res_q.push_back(predict());
        foreach (cyc_tab[i]) begin
            drive(cyc_tab[i]);
            idle(gap);
        end
        wait_done(400);
        idle(lat_max + 3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_exp_req"}, 64'(exp_req), 64'd0);
        check({tag, "_exp_addr"}, 64'(exp_addr), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_pass"}, 64'(pass), 64'd0);
        check({tag, "_err_code"}, 64'(err_code), 64'd0);
        check({tag, "_err_index"}, 64'(err_index), 64'd0);
        check({tag, "_inst_count"}, 64'(inst_count), 64'd0);
    endtask

    initial begin
        cyc_t c;
        int   nc, sel, mode, j, n;
        clear_inputs();
        clear_mem();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Single register write, then halt.
        do_reset(); clear_mem(); lat_min = 1; lat_max = 2;
        cyc_tab.delete();
        cyc_tab.push_back(mk(1, 3'd3, 16'h1234, 0, 0, 16'd0, 16'd0, 16'd0, 0));
        cyc_tab.push_back(mk(0, 3'd0, 16'd0, 0, 0, 16'd0, 16'd0, 16'd0, 1));
        mem[0] = {2'b01, 16'h0003, 16'h1234};
        run_seq(8);

        // Load with writeback: REG must come before LOAD.
        do_reset(); clear_mem();
        cyc_tab.delete();
        cyc_tab.push_back(mk(1, 3'd1, 16'hBEEF, 1, 0, 16'h0040, 16'd0, 16'hBEEF, 0));
        cyc_tab.push_back(mk(0, 3'd0, 16'd0, 0, 0, 16'd0, 16'd0, 16'd0, 1));
        mem[0] = {2'b01, 16'h0001, 16'hBEEF};
        mem[1] = {2'b10, 16'h0040, 16'hBEEF};
        run_seq(10);
        do_reset();
        mem[0] = {2'b10, 16'h0040, 16'hBEEF};
        mem[1] = {2'b01, 16'h0001, 16'hBEEF};
        run_seq(10);

        // Store mismatch; later events must be ignored.
        do_reset(); clear_mem();
        cyc_tab.delete();
        cyc_tab.push_back(mk(0, 3'd0, 16'd0, 0, 1, 16'h0010, 16'h0005, 16'd0, 0));
        mem[0] = {2'b11, 16'h0010, 16'h0006};
        run_seq(6);
        drive(mk(1, 3'd2, 16'h7777, 0, 1, 16'h0020, 16'h0001, 16'd0, 1));
        for (int i = 0; i < 6; i++) begin
            check("post_done_req", 64'(exp_req), 64'd0);
            drive(mk(1, 3'd4, 16'h1111, 1, 0, 16'h0030, 16'd0, 16'h2222, 0));
        end
        check("post_done_done", 64'(done), 64'd1);
        check("post_done_code", 64'(err_code), 64'd1);
        check("post_done_index", 64'(err_index), 64'd0);
        check("post_done_inst", 64'(inst_count), 64'd1);

        // Overflow: latency 5, two records every cycle.
        do_reset(); clear_mem(); lat_min = 5; lat_max = 5;
        cyc_tab.delete();
        for (int i = 0; i < 12; i++)
            cyc_tab.push_back(mk(1, 3'(i), 16'(16'h0100 + i), 0, 1, 16'(i * 2), 16'(i * 3), 16'd0, 0));
        build_recs();
        foreach (ref_recs[i]) mem[i] = ref_recs[i];
        begin
            res_t r;
            r.pass = 1'b0; r.code = 3'd2; r.idx = 16'd0; r.chk_idx = 1'b0;
            r.chk_inst = 1'b0; r.inst = 32'd0;
            res_q.push_back(r);
        end
        foreach (cyc_tab[i]) begin
            if (done) break;
            drive(cyc_tab[i]);
        end
        wait_done(50);
        check("ovf_index", 64'(err_index), 64'(resp_delivered));
        idle(8);
        check("ovf_index_held", 64'(err_index), 64'(resp_delivered));

        // Trace too short, then trace too long.
        do_reset(); clear_mem(); lat_min = 1; lat_max = 3;
        cyc_tab.delete();
        cyc_tab.push_back(mk(1, 3'd1, 16'h00A1, 0, 0, 16'd0, 16'd0, 16'd0, 0));
        cyc_tab.push_back(mk(1, 3'd2, 16'h00B2, 0, 0, 16'd0, 16'd0, 16'd0, 0));
        cyc_tab.push_back(mk(0, 3'd0, 16'd0, 0, 0, 16'd0, 16'd0, 16'd0, 1));
        mem[0] = {2'b01, 16'h0001, 16'h00A1};
        run_seq(10);
        do_reset(); clear_mem();
        cyc_tab.delete();
        cyc_tab.push_back(mk(1, 3'd1, 16'h00A1, 0, 0, 16'd0, 16'd0, 16'd0, 0));
        cyc_tab.push_back(mk(0, 3'd0, 16'd0, 0, 0, 16'd0, 16'd0, 16'd0, 1));
        mem[0] = {2'b01, 16'h0001, 16'h00A1};
        mem[1] = {2'b01, 16'h0002, 16'h00B2};
        run_seq(10);

        // Reset while waiting on a response; the late response must be ignored.
        do_reset(); clear_mem(); lat_min = 3; lat_max = 3;
        cyc_tab.delete();
        cyc_tab.push_back(mk(1, 3'd2, 16'hAAAA, 0, 0, 16'd0, 16'd0, 16'd0, 0));
        cyc_tab.push_back(mk(0, 3'd0, 16'd0, 0, 0, 16'd0, 16'd0, 16'd0, 1));
        mem[0] = {2'b01, 16'h0002, 16'hAAAA};
        drive(cyc_tab[0]);
        begin
            int k;
            k = 0;
            while (!exp_req && k < 20) begin idle(1); k++; end
            check("midrst_req_seen", 64'(exp_req), 64'd1);
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_reset_outputs("midrst");
            idle(1);
        end
        wait_resp_idle();
        idle(2);
        run_seq(8);

        // Randomized sequences with a randomly corrupted expected trace.
        for (int t = 0; t < 30; t++) begin
            do_reset(); clear_mem();
            lat_min = 1; lat_max = $urandom_range(4, 1);
            cyc_tab.delete();
            nc = $urandom_range(5, 1);
            for (int i = 0; i < nc; i++) begin
                sel = $urandom_range(5, 0);
                c = mk(sel == 0 || sel == 3 || sel == 4, 3'($urandom), 16'($urandom),
                       sel == 1 || sel == 3 || sel == 5, sel == 2 || sel == 4 || sel == 5,
                       16'($urandom), 16'($urandom), 16'($urandom), 0);
                cyc_tab.push_back(c);
            end
            if ($urandom_range(1, 0) == 1) cyc_tab[nc - 1].halt = 1'b1;
            else cyc_tab.push_back(mk(0, 3'd0, 16'd0, 0, 0, 16'd0, 16'd0, 16'd0, 1));
            build_recs();
            n = ref_recs.size();
            foreach (ref_recs[i]) mem[i] = ref_recs[i];
            mem[n] = {2'b00, 32'($urandom)};
            mode = $urandom_range(3, 0);
            j = $urandom_range(n - 1, 0);
            if (mode == 1) mem[j] = mem[j] ^ (34'd1 << $urandom_range(31, 0));
            else if (mode == 2) mem[j] = {2'b00, 32'd0};
            else if (mode == 3) begin
                mem[n] = {2'b01, 32'($urandom)};
                mem[n + 1] = {2'b00, 32'd0};
            end
            run_seq(2 * (lat_max + 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
